// File: rtl/wb_spi_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : wb_spi_reg_loader
// Purpose  : Wishbone slave that queues words in a small FIFO and shifts each
//            out as an SPI mode-0 frame to the raybox reg or vec port.
//            Optional macro SPI_LOADER_IRQ_EN builds the idle interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module wb_spi_reg_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        reg_csb,
  output logic        reg_sclk,
  output logic        reg_mosi,
  output logic        vec_csb,
  output logic        vec_sclk,
  output logic        vec_mosi,
  output logic        irq
);

  localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [2:0] c_ST_IDLE  = 3'd0;
  localparam logic [2:0] c_ST_SETUP = 3'd1;
  localparam logic [2:0] c_ST_HIGH  = 3'd2;
  localparam logic [2:0] c_ST_LOW   = 3'd3;
  localparam logic [2:0] c_ST_GAP   = 3'd4;

  logic              r_ack, r_done;
  logic [1:0]        r_adr_q;
  logic [31:0]       r_dat;
  logic [7:0]        r_div_cfg;
  logic [4:0]        r_len_cfg;
  logic              r_tgt_cfg, r_ovf;
  logic [45:0]       r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wptr, r_rptr;
  logic [c_PTR_W:0]  r_level;
  logic [2:0]        r_state;
  logic [7:0]        r_cnt, r_div;
  logic [5:0]        r_bits;
  logic [31:0]       r_sh;
  logic              r_tgt;

  logic        w_req, w_fire, w_wr, w_rd, w_push, w_pop, w_empty, w_full, w_busy;
  logic        w_active, w_csb, w_sclk, w_mosi, w_unused;
  logic [1:0]  w_off;
  logic [2:0]  w_lvl;
  logic [31:0] w_rdata;
  logic [45:0] w_head;

  // An ack is issued once per strobe; holding stb on the same register blocks repeats.
  assign w_req   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign w_off   = wbs_adr_i[3:2];
  assign w_fire  = w_req & ~r_ack & ~(r_done & (w_off == r_adr_q));
  assign w_wr    = w_fire & wbs_we_i;
  assign w_rd    = w_fire & ~wbs_we_i;
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_FULL);
  assign w_busy  = (r_state != c_ST_IDLE);
  assign w_lvl   = 3'(r_level);
  assign w_head  = r_mem[r_rptr];
  assign w_pop   = ~w_empty & ((r_state == c_ST_IDLE) | ((r_state == c_ST_GAP) & (r_cnt == 8'd0)));
  assign w_push  = w_wr & (w_off == 2'd1) & (~w_full | w_pop);
  assign w_unused = ^{wbs_sel_i[3], wbs_adr_i[1:0]};

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      2'd0:    w_rdata = {15'd0, r_tgt_cfg, 3'd0, r_len_cfg, r_div_cfg};
      2'd2:    w_rdata = {26'd0, r_ovf, w_full, w_lvl, w_busy};
      default: w_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_done    <= 1'b0;
      r_adr_q   <= 2'd0;
      r_dat     <= 32'd0;
      r_div_cfg <= 8'd0;
      r_len_cfg <= 5'd23;
      r_tgt_cfg <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_ack <= w_fire;
      r_dat <= w_rd ? w_rdata : 32'd0;
      if (w_fire) begin
        r_done  <= 1'b1;
        r_adr_q <= w_off;
      end else if (~wbs_stb_i) begin
        r_done <= 1'b0;
      end
      if (w_wr && w_off == 2'd0) begin
        if (wbs_sel_i[0]) r_div_cfg <= wbs_dat_i[7:0];
        if (wbs_sel_i[1]) r_len_cfg <= wbs_dat_i[12:8];
        if (wbs_sel_i[2]) r_tgt_cfg <= wbs_dat_i[16];
      end
      if (w_wr && w_off == 2'd1 && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_wr && w_off == 2'd2 && wbs_dat_i[5]) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wptr] <= {r_tgt_cfg, r_len_cfg, r_div_cfg, wbs_dat_i};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  // Data is left-aligned at pop so the current bit is always r_sh[31].
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 8'd0;
      r_div   <= 8'd0;
      r_bits  <= 6'd0;
      r_sh    <= 32'd0;
      r_tgt   <= 1'b0;
    end else if (w_pop) begin
      r_state <= c_ST_SETUP;
      r_tgt   <= w_head[45];
      r_bits  <= 6'(w_head[44:40]) + 6'd1;
      r_div   <= w_head[39:32];
      r_cnt   <= w_head[39:32];
      r_sh    <= w_head[31:0] << (5'd31 - w_head[44:40]);
    end else if (r_state != c_ST_IDLE) begin
      if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end else begin
        r_cnt <= r_div;
        case (r_state)
          c_ST_SETUP: r_state <= c_ST_HIGH;
          c_ST_HIGH: begin
            r_state <= c_ST_LOW;
            r_bits  <= r_bits - 6'd1;
            if (r_bits != 6'd1) r_sh <= {r_sh[30:0], 1'b0};
          end
          c_ST_LOW:  r_state <= (r_bits == 6'd0) ? c_ST_GAP : c_ST_HIGH;
          default:   r_state <= c_ST_IDLE;
        endcase
      end
    end
  end

  assign w_active = (r_state == c_ST_SETUP) | (r_state == c_ST_HIGH) | (r_state == c_ST_LOW);
  assign w_csb    = ~w_active;
  assign w_sclk   = (r_state == c_ST_HIGH);
  assign w_mosi   = w_active & r_sh[31];

  assign reg_csb  = r_tgt ? 1'b1 : w_csb;
  assign reg_sclk = ~r_tgt & w_sclk;
  assign reg_mosi = ~r_tgt & w_mosi;
  assign vec_csb  = r_tgt ? w_csb : 1'b1;
  assign vec_sclk = r_tgt & w_sclk;
  assign vec_mosi = r_tgt & w_mosi;

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

`ifdef SPI_LOADER_IRQ_EN
  logic r_idle_entry, r_irq;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_idle_entry <= 1'b0;
      r_irq        <= 1'b0;
    end else begin
      r_idle_entry <= (r_state == c_ST_GAP) & (r_cnt == 8'd0) & ~w_pop;
      if ((w_wr && w_off == 2'd1) || (w_rd && w_off == 2'd2)) r_irq <= 1'b0;
      else if (r_idle_entry && w_empty)                       r_irq <= 1'b1;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_spi_reg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_spi_reg_loader
// Purpose  : Self-checking bench for wb_spi_reg_loader with a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_spi_reg_loader;

  localparam logic [31:0] c_BASE = 32'h3000_0100;
  localparam logic [31:0] c_CTRL = c_BASE + 32'h0;
  localparam logic [31:0] c_DATA = c_BASE + 32'h4;
  localparam logic [31:0] c_STAT = c_BASE + 32'h8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic        ack;
  logic [31:0] rdat;
  logic        reg_csb, reg_sclk, reg_mosi, vec_csb, vec_sclk, vec_mosi, irq;

  int n_chk = 0;
  int n_fail = 0;
  int cycn = 0;

  wb_spi_reg_loader #(.BASE_ADDR(c_BASE), .FIFO_DEPTH(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .reg_csb(reg_csb), .reg_sclk(reg_sclk), .reg_mosi(reg_mosi),
    .vec_csb(vec_csb), .vec_sclk(vec_sclk), .vec_mosi(vec_mosi),
    .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycn <= cycn + 1;

  // Line monitor: bits captured at sclk rises, csb-low run lengths, csb-high runs before each fall.
  bit q_reg[$];
  bit q_vec[$];
  int low_reg[$];
  int low_vec[$];
  int gap_q[$];
  logic p_rs = 1'b0, p_vs = 1'b0, p_rc = 1'b1, p_vc = 1'b1;
  int run_rl = 0, run_vl = 0, run_rh = 0, fall_cyc = 0, n_falls = 0;
  bit irq_seen = 1'b0;

  always @(negedge clk) begin
    if (reg_sclk && !p_rs) q_reg.push_back(reg_mosi);
    if (vec_sclk && !p_vs) q_vec.push_back(vec_mosi);
    if (reg_csb && !p_rc) low_reg.push_back(run_rl);
    if (vec_csb && !p_vc) low_vec.push_back(run_vl);
    if (!reg_csb && p_rc) gap_q.push_back(run_rh);
    if ((!reg_csb && p_rc) || (!vec_csb && p_vc)) begin
      fall_cyc <= cycn;
      n_falls  <= n_falls + 1;
    end
    if (irq) irq_seen <= 1'b1;
    run_rl <= reg_csb ? 0 : run_rl + 1;
    run_vl <= vec_csb ? 0 : run_vl + 1;
    run_rh <= reg_csb ? run_rh + 1 : 0;
    p_rs <= reg_sclk; p_vs <= vec_sclk; p_rc <= reg_csb; p_vc <= vec_csb;
  end

  task automatic clear_mon();
    q_reg.delete(); q_vec.delete(); low_reg.delete(); low_vec.delete(); gap_q.delete();
  endtask

  task automatic wb_xfer(input logic iwe, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output int ack_c);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = iwe; adr = a; wdat = d; sel = s;
    ack_c = -1; rd = 32'hx;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin rd = rdat; ack_c = cycn; break; end
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    n_chk++;
    if (ack_c < 0) begin
      n_fail++;
      $display("FAIL wb_ack_timeout: adr=%h got no ack, required an ack", a);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; int c;
    wb_xfer(1'b1, a, d, 4'hF, rd, c);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
    int c;
    wb_xfer(1'b0, a, 32'd0, 4'hF, rd, c);
  endtask

  task automatic wait_quiet(input string nm);
    int q = 0, t = 0;
    while (q < 12 && t < 4000) begin
      @(negedge clk); t++;
      if (reg_csb && vec_csb) q++; else q = 0;
    end
    n_chk++;
    if (q < 12) begin
      n_fail++;
      $display("FAIL %s_quiet_timeout: SPI still active after %0d cycles, required idle", nm, t);
    end
  endtask

  function automatic logic [31:0] mask_len(input int l, input logic [31:0] d);
    logic [31:0] m;
    m = (l == 32) ? 32'hFFFF_FFFF : ((32'h1 << l) - 32'h1);
    return d & m;
  endfunction

  task automatic test_reset();
    logic [31:0] rd;
    n_chk++;
    if ({ack, rdat, reg_csb, reg_sclk, reg_mosi, vec_csb, vec_sclk, vec_mosi, irq} !==
        {1'b0, 32'd0, 1'b1, 2'b00, 1'b1, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b dat=%h reg=%b%b%b vec=%b%b%b irq=%b, required 0 0 100 100 0",
               ack, rdat, reg_csb, reg_sclk, reg_mosi, vec_csb, vec_sclk, vec_mosi, irq);
    end
    wb_read(c_CTRL, rd);
    n_chk++;
    if (rd !== 32'h0000_1700) begin n_fail++; $display("FAIL reset_ctrl: got %h, required 00001700", rd); end
    wb_read(c_STAT, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h, required 00000000", rd); end
    begin
      int c;
      wb_xfer(1'b1, c_CTRL, 32'hFFFF_FFFF, 4'b0001, rd, c);
    end
    wb_read(c_CTRL, rd);
    n_chk++;
    if (rd !== 32'h0000_17FF) begin n_fail++; $display("FAIL ctrl_bytesel: got %h, required 000017FF", rd); end
    wb_write(c_CTRL, 32'h0000_1700);
  endtask

  task automatic test_ack_rules();
    int acks = 0;
    logic [31:0] rd;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = c_STAT; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (ack) acks++; end
    adr = c_BASE + 32'h200;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (ack) acks++; end
    stb = 1'b0; cyc = 1'b0;
    n_chk++;
    if (acks != 1) begin n_fail++; $display("FAIL ack_held_and_nomatch: got %0d acks, required 1", acks); end
    wb_read(c_BASE + 32'hC, rd);
    n_chk++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL read_0xC: got %h, required 0", rd); end
    wb_read(c_DATA, rd);
    n_chk++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL read_data: got %h, required 0", rd); end
  endtask

  task automatic test_basic();
    logic [31:0] act = 0, rd;
    int ack_c;
    wb_write(c_CTRL, 32'h0000_0700);
    clear_mon();
    wb_xfer(1'b1, c_DATA, 32'h0000_00A5, 4'hF, rd, ack_c);
    wait_quiet("basic");
    foreach (q_reg[i]) act = {act[30:0], q_reg[i]};
    n_chk++;
    if (q_reg.size() != 8 || act !== 32'hA5) begin
      n_fail++; $display("FAIL basic_bits: got %0d bits value %h, required 8 bits a5", q_reg.size(), act);
    end
    n_chk++;
    if (low_reg.size() != 1 || low_reg[0] != 17) begin
      n_fail++; $display("FAIL basic_csb_low: got %p, required one run of 17", low_reg);
    end
    n_chk++;
    if (q_vec.size() != 0 || low_vec.size() != 0) begin
      n_fail++; $display("FAIL basic_vec_static: got %0d edges %0d frames, required 0 0", q_vec.size(), low_vec.size());
    end
    n_chk++;
    if (fall_cyc - ack_c != 1) begin
      n_fail++; $display("FAIL basic_latency: got %0d, required 1 cycle ack->csb fall", fall_cyc - ack_c);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d[6];
    logic [31:0] rd, act;
    int bad = 0;
    wb_write(c_CTRL, 32'h0000_0703);
    clear_mon();
    for (int k = 0; k < 6; k++) begin d[k] = $urandom; wb_write(c_DATA, d[k]); end
    wb_write(c_CTRL, 32'h0000_0F00);
    wb_read(c_STAT, rd);
    n_chk++;
    if (rd !== 32'h39) begin n_fail++; $display("FAIL ovf_status_full: got %h, required 39", rd); end
    wait_quiet("ovf");
    // One entry is in flight, four queued: the sixth write is the dropped one.
    n_chk++;
    if (q_reg.size() != 40) begin n_fail++; $display("FAIL ovf_bitcount: got %0d, required 40", q_reg.size()); end
    for (int f = 0; f < 5; f++) begin
      act = 0;
      for (int b = 0; b < 8; b++) if (f*8 + b < q_reg.size()) act = {act[30:0], q_reg[f*8 + b]};
      if (act !== mask_len(8, d[f])) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL ovf_order: %0d frames wrong, required 0", bad); end
    bad = 0;
    foreach (low_reg[i]) if (low_reg[i] != 68) bad++;
    for (int i = 1; i < gap_q.size(); i++) if (gap_q[i] != 4) bad++;
    n_chk++;
    if (bad != 0 || gap_q.size() != 5) begin
      n_fail++; $display("FAIL ovf_timing: low=%p gaps=%p, required lows 68 and gaps 4", low_reg, gap_q);
    end
    wb_read(c_STAT, rd);
    n_chk++;
    if (rd !== 32'h20) begin n_fail++; $display("FAIL ovf_sticky: got %h, required 20", rd); end
    wb_write(c_STAT, 32'h20);
    wb_read(c_STAT, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL ovf_clear: got %h, required 0", rd); end
  endtask

  task automatic test_vec32();
    logic [31:0] act = 0;
    wb_write(c_CTRL, 32'h0001_1F00);
    clear_mon();
    wb_write(c_DATA, 32'hDEAD_BEEF);
    wait_quiet("vec32");
    foreach (q_vec[i]) act = {act[30:0], q_vec[i]};
    n_chk++;
    if (q_vec.size() != 32 || act !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL vec32_bits: got %0d bits %h, required 32 bits deadbeef", q_vec.size(), act);
    end
    n_chk++;
    if (q_reg.size() != 0 || low_vec.size() != 1 || low_vec[0] != 65) begin
      n_fail++; $display("FAIL vec32_frame: reg edges %0d vec lows %p, required 0 and 65", q_reg.size(), low_vec);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int div, len, tgt, h;
      logic [31:0] d, act;
      div = $urandom_range(0, 3); len = $urandom_range(1, 32); tgt = $urandom_range(0, 1);
      d = $urandom; h = div + 1; act = 0;
      wb_write(c_CTRL, (32'(tgt) << 16) | (32'(len - 1) << 8) | 32'(div));
      clear_mon();
      wb_write(c_DATA, d);
      wait_quiet("rand");
      if (tgt == 1) foreach (q_vec[i]) act = {act[30:0], q_vec[i]};
      else          foreach (q_reg[i]) act = {act[30:0], q_reg[i]};
      n_chk++;
      if (act !== mask_len(len, d) ||
          (tgt == 1 ? q_vec.size() : q_reg.size()) != len ||
          (tgt == 1 ? q_reg.size() : q_vec.size()) != 0) begin
        n_fail++; $display("FAIL rand_bits[%0d]: len=%0d tgt=%0d got %h, required %h", it, len, tgt, act, mask_len(len, d));
      end
      n_chk++;
      if ((tgt == 1 ? low_vec.size() : low_reg.size()) != 1 ||
          (tgt == 1 ? low_vec[0] : low_reg[0]) != h * (2 * len + 1)) begin
        n_fail++; $display("FAIL rand_len[%0d]: lows reg=%p vec=%p, required %0d", it, low_reg, low_vec, h * (2 * len + 1));
      end
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
`ifdef SPI_LOADER_IRQ_EN
    wb_write(c_CTRL, 32'h0000_0700);
    wb_write(c_DATA, 32'h3C);
    wait_quiet("irq");
    n_chk++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b, required 1", irq); end
    wb_read(c_STAT, rd);
    @(negedge clk);
    n_chk++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear: got %b, required 0", irq); end
`else
    wb_read(c_STAT, rd);
    n_chk++;
    if (irq_seen !== 1'b0) begin n_fail++; $display("FAIL irq_tied: irq seen %b, required 0", irq_seen); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int t = 0, nq, nf;
    wb_write(c_CTRL, 32'h0000_0F01);
    clear_mon();
    for (int k = 0; k < 3; k++) wb_write(c_DATA, $urandom);
    while (q_reg.size() < 10 && t < 500) begin @(negedge clk); t++; end
    n_chk++;
    if (q_reg.size() < 10) begin n_fail++; $display("FAIL rstmid_wait: got %0d bits, required 10", q_reg.size()); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({reg_csb, reg_sclk, reg_mosi} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b, required 100", {reg_csb, reg_sclk, reg_mosi});
    end
    rst = 1'b0;
    nq = q_reg.size(); nf = n_falls;
    repeat (100) @(negedge clk);
    n_chk++;
    if (q_reg.size() != nq || n_falls != nf) begin
      n_fail++; $display("FAIL rstmid_resume: edges %0d->%0d falls %0d->%0d, required no change", nq, q_reg.size(), nf, n_falls);
    end
    wb_read(c_STAT, rd);
    n_chk++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_status: got %h, required 0", rd); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ack_rules();
    test_basic();
    test_overflow();
    test_vec32();
    test_random();
    test_irq();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
